ram_unit_param: RTL

- Parametrised successor to the processor's 256x16 data RAM.
- Generalised in data width and depth.
- Replaces tri-state read muxing with a registered read port plus a valid strobe.
- Adds a hardware stack region (PUSH/POP with pointer and flags) and a self-timed CLEAR sequence.
- Sits on the shared opcode/operand bus beside ROM, ALU/REG and PC blocks; decodes the same select/operation nibbles.

---
 rtl/proc_pkg.sv | 46 ++++
 rtl/ram_unit_param_if.sv | 28 ++
 rtl/ram_sp_array.sv | 28 ++
 rtl/ram_unit_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared opcode/operand bus constants, FSM states and command decode.
package proc_pkg;

   // Select nibble, opcode[DW-1:DW-4]
   localparam logic [3:0] RAM_OP = 4'h4;
   localparam logic [3:0] ROM_OP = 4'h3;
   localparam logic [3:0] REG_OP = 4'h9;
   localparam logic [3:0] PC_OP  = 4'h7;

   // Operation nibble, opcode[DW-5:DW-8]
   localparam logic [3:0] OP_WRITE = 4'd1;
   localparam logic [3:0] OP_READ  = 4'd2;
   localparam logic [3:0] OP_PUSH  = 4'd3;
   localparam logic [3:0] OP_POP   = 4'd4;
   localparam logic [3:0] OP_CLEAR = 4'd5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // One-hot-or-zero decoded command, already qualified by its enable
   typedef struct packed {
      logic wr;
      logic rd;
      logic push;
      logic pop;
      logic clr;
   } cmd_t;

   // Decode select/operation; each command only looks at its own enable
   function automatic cmd_t decode_cmd(input logic [3:0] sel, input logic [3:0] op,
                                       input logic re, input logic we);
      cmd_t c;
      logic stk;
      c      = '0;
      stk    = (sel == RAM_OP) || (sel == REG_OP);
      c.wr   = we && (op == OP_WRITE) && (stk || (sel == ROM_OP));
      c.rd   = re && ((stk && (op == OP_READ)) || (sel == PC_OP));
      c.push = we && stk && (op == OP_PUSH);
      c.pop  = re && stk && (op == OP_POP);
      c.clr  = we && (sel == RAM_OP) && (op == OP_CLEAR);
      return c;
   endfunction

endpackage

// File: rtl/ram_unit_param_if.sv
// Opcode/operand bus as seen by the data RAM.
interface ram_unit_param_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CNT_W      = 6
);
   logic [DATA_WIDTH-1:0] opcode;
   logic [DATA_WIDTH-1:0] operand;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  read_enable;
   logic                  write_enable;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_valid;
   logic                  busy;
   logic [CNT_W-1:0]      stack_count;
   logic                  stack_full;
   logic                  stack_empty;
   logic                  error;

   modport master (
      output opcode, operand, write_data, read_enable, write_enable,
      input  read_data, read_valid, busy, stack_count, stack_full, stack_empty, error
   );

   modport slave (
      input  opcode, operand, write_data, read_enable, write_enable,
      output read_data, read_valid, busy, stack_count, stack_full, stack_empty, error
   );
endinterface

// File: rtl/ram_sp_array.sv
// Single-port synchronous RAM, read-first, with a resettable read register.
module ram_sp_array #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  re,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Read register loads only on reads and samples the pre-write word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/ram_unit_param.sv
// Data RAM with registered read port, hardware stack and self-timed clear.
module ram_unit_param
   import proc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned STACK_BASE  = 224,
   parameter int unsigned STACK_DEPTH = 32
) (
   input logic        clk,
   input logic        reset,
   ram_unit_param_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

   logic [3:0]            sel;
   logic [3:0]            op;
   cmd_t                  cmd_c;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] src_data;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic [ADDR_WIDTH-1:0] pop_addr;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_next;
   logic [CNT_W-1:0]      count, count_next;
   logic                  full, empty, busy;
   logic                  read_valid, error;
   logic                  busy_next, rvalid_next, err_next;

   logic                  arr_re, arr_we;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [DATA_WIDTH-1:0] arr_wdata;

   assign sel       = bus.opcode[DATA_WIDTH-1 -: 4];
   assign op        = bus.opcode[DATA_WIDTH-5 -: 4];
   assign cmd_c     = decode_cmd(sel, op, bus.read_enable, bus.write_enable);
   assign cmd_addr  = (sel == ROM_OP) ? bus.opcode[ADDR_WIDTH-1:0] : bus.operand[ADDR_WIDTH-1:0];
   assign src_data  = (sel == RAM_OP) ? bus.operand : bus.write_data;
   assign push_addr = ADDR_WIDTH'(STACK_BASE) + ADDR_WIDTH'(count);
   assign pop_addr  = push_addr - ADDR_WIDTH'(1);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next state: clear runs exactly one pass over the array
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (cmd_c.clr) state_next = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs and datapath controls for the current state and command
   always_comb begin
      arr_re       = 1'b0;
      arr_we       = 1'b0;
      arr_addr     = cmd_addr;
      arr_wdata    = src_data;
      count_next   = count;
      clr_cnt_next = '0;
      rvalid_next  = 1'b0;
      err_next     = 1'b0;
      busy_next    = (state_next == ST_CLEAR);
      case (state)
         ST_CLEAR: begin
            arr_we       = 1'b1;
            arr_addr     = clr_cnt;
            arr_wdata    = '0;
            clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
            err_next     = bus.read_enable | bus.write_enable;
         end
         default: begin
            if (cmd_c.wr) arr_we = 1'b1;
            if (cmd_c.rd) begin
               arr_re      = 1'b1;
               rvalid_next = 1'b1;
            end
            if (cmd_c.push) begin
               if (count == CNT_W'(STACK_DEPTH)) begin
                  err_next = 1'b1;
               end else begin
                  arr_we     = 1'b1;
                  arr_addr   = push_addr;
                  count_next = count + CNT_W'(1);
               end
            end
            if (cmd_c.pop) begin
               if (count == '0) begin
                  err_next = 1'b1;
               end else begin
                  arr_re      = 1'b1;
                  arr_addr    = pop_addr;
                  count_next  = count - CNT_W'(1);
                  rvalid_next = 1'b1;
               end
            end
            if (cmd_c.clr) count_next = '0;
         end
      endcase
   end

   // Registered status, counters and strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt    <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         busy       <= 1'b0;
         read_valid <= 1'b0;
         error      <= 1'b0;
      end else begin
         clr_cnt    <= clr_cnt_next;
         count      <= count_next;
         full       <= (count_next == CNT_W'(STACK_DEPTH));
         empty      <= (count_next == '0);
         busy       <= busy_next;
         read_valid <= rvalid_next;
         error      <= err_next;
      end
   end

   ram_sp_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk  (clk),
      .reset(reset),
      .re   (arr_re),
      .we   (arr_we),
      .addr (arr_addr),
      .wdata(arr_wdata),
      .rdata(bus.read_data)
   );

   assign bus.read_valid  = read_valid;
   assign bus.busy        = busy;
   assign bus.stack_count = count;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.error       = error;
endmodule
